fifo_drain_ctrl: RTL and testbench

// - Sequences the TX byte FIFO into the UART transmitter: pops one byte, captures it, issues tx_start, waits out the frame.
// - Sits between the AXI-Lite-fed FIFO (read side) and the UART TX. Sole owner of the FIFO read port.
// - Also provides a flush path and a sticky error flag when the UART fails to acknowledge a start.

---
 rtl/fifo_drain_pkg.sv | 21 ++
 rtl/fifo_drain_ctrl_timer.sv | 29 ++
 rtl/fifo_drain_ctrl.sv | 150 +++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared state type and timer sizing helper for the TX FIFO drain controller.
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        LATCH     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5,
        FLUSH     = 3'd6
    } drain_state_t;

    // Bits needed to hold the larger of the two timer reload values.
    function automatic int timer_width(input int ack_timeout, input int gap_cycles);
        int m;
        m = (ack_timeout > gap_cycles) ? ack_timeout : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_timer.sv
// Loadable down-counter shared by the ack timeout and the inter-byte gap.
module drain_timer
    import fifo_drain_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains the TX byte FIFO into the UART transmitter, with flush and ack-timeout error.
// Optional inter-byte idle gap enabled by defining FIFO_DRAIN_GAP_EN.
//
// state     | meaning
// IDLE      | waiting for a byte (or a pending flush)
// POP       | fifo_read_en asserted for one cycle
// LATCH     | capture fifo_dout, pulse tx_start, arm ack timer
// WAIT_ACK  | waiting for tx_busy to rise
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
// GAP       | extra idle cycles after a frame (FIFO_DRAIN_GAP_EN only)
// FLUSH     | popping until the FIFO reports empty
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read_en,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      sent_count,
    output logic                  err_ack
);

    localparam int TIMER_W = timer_width(ACK_TIMEOUT, GAP_CYCLES);
    localparam logic [TIMER_W-1:0] ACK_LOAD = TIMER_W'(ACK_TIMEOUT - 1);
`ifdef FIFO_DRAIN_GAP_EN
    localparam bit GAP_ON = (GAP_CYCLES > 0);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
`endif

    drain_state_t         state;
    logic                 flush_pend;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic                 tmr_zero;
    logic [TIMER_W-1:0]   tmr_load_val;

    // Timer controls are decoded from the current state so a load in
    // LATCH is visible on the first WAIT_ACK cycle.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = ACK_LOAD;
        tmr_dec      = 1'b0;
        case (state)
            LATCH:    tmr_load = 1'b1;
            WAIT_ACK: tmr_dec  = !tx_busy;
`ifdef FIFO_DRAIN_GAP_EN
            WAIT_DONE: begin
                if (GAP_ON && !tx_busy) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LOAD;
                end
            end
            GAP:      tmr_dec  = 1'b1;
`endif
            default: ;
        endcase
    end

    drain_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            flush_pend   <= 1'b0;
            fifo_read_en <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            sent_count   <= '0;
            err_ack      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        state <= FLUSH;
                    end else if (enable && !fifo_empty && !tx_busy) begin
                        fifo_read_en <= 1'b1;
                        state        <= POP;
                    end
                end
                POP: begin
                    fifo_read_en <= 1'b0;
                    state        <= LATCH;
                end
                LATCH: begin
                    tx_data  <= fifo_dout;
                    tx_start <= 1'b1;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmr_zero) begin
                        err_ack <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        sent_count <= sent_count + CNT_W'(1);
`ifdef FIFO_DRAIN_GAP_EN
                        state      <= GAP_ON ? GAP : IDLE;
`else
                        state      <= IDLE;
`endif
                    end
                end
`ifdef FIFO_DRAIN_GAP_EN
                GAP: begin
                    if (tmr_zero) state <= IDLE;
                end
`endif
                FLUSH: begin
                    if (fifo_empty) begin
                        fifo_read_en <= 1'b0;
                        flush_pend   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        fifo_read_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new flush pulse outranks the clear on FLUSH exit.
            if (flush) flush_pend <= 1'b1;
        end
    end

    assign busy = (state != IDLE) || flush_pend;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: queue-based FIFO and UART models plus directed and random traffic.
module tb_fifo_drain_ctrl;

    localparam int DW     = 8;
    localparam int CW     = 16;
    localparam int ACK_TO = 4;
    localparam int GAP_N  = 3;
`ifdef FIFO_DRAIN_GAP_EN
    localparam int EXP_GAP = GAP_N;
`else
    localparam int EXP_GAP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_read_en;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic [CW-1:0] sent_count;
    logic          err_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fifo_drain_ctrl #(
        .DATA_WIDTH  (DW),
        .CNT_W       (CW),
        .ACK_TIMEOUT (ACK_TO),
        .GAP_CYCLES  (GAP_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_read_en (fifo_read_en),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .sent_count   (sent_count),
        .err_ack      (err_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: pop on a sampled read request, data valid the next cycle.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (fifo_read_en === 1'b1 && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // UART model and start monitor.
    logic [DW-1:0] exp_q[$];
    int n_starts = 0, ref_sent = 0, start_cyc = -1, busy_fall_cyc = -1;
    int rd_rise_cyc = -1, rd_run = 0, rd_last_run = 0;
    int frame_len = 10, ack_dly = 0, ack_wait = 0, busy_left = 0;
    bit uart_ack_en = 1'b1, rand_uart = 1'b0, prev_rd = 1'b0;

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_starts++;
            start_cyc = cyc;
            check("start_while_uart_busy", {31'd0, tx_busy}, 32'd0);
            check("start_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                tx_busy = 1'b0;
                ref_sent++;
                busy_fall_cyc = cyc;
            end
        end
        if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) begin
                tx_busy   = 1'b1;
                busy_left = frame_len;
            end
        end
        if (tx_start === 1'b1 && uart_ack_en) begin
            if (rand_uart) begin
                frame_len = $urandom_range(2, 12);
                ack_dly   = $urandom_range(0, ACK_TO - 1);
            end
            if (ack_dly == 0) begin
                tx_busy   = 1'b1;
                busy_left = frame_len;
            end else begin
                ack_wait = ack_dly;
            end
        end
        if (fifo_read_en === 1'b1) begin
            if (!prev_rd) begin
                rd_rise_cyc = cyc;
                rd_run      = 1;
            end else begin
                rd_run++;
            end
        end else if (prev_rd) begin
            rd_last_run = rd_run;
        end
        prev_rd = (fifo_read_en === 1'b1);
    end

    task automatic push(input logic [DW-1:0] b, input bit will_send);
        fq.push_back(b);
        if (will_send) exp_q.push_back(b);
    endtask

    task automatic wait_quiet(input string tag);
        int stable = 0;
        for (int i = 0; i < 3000 && stable < 4; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_busy === 1'b0 && ack_wait == 0 && (fq.size() == 0 || !enable))
                stable++;
            else
                stable = 0;
        end
        check({tag, "_settle"}, {31'd0, stable >= 4}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int i = 0;
        while (n_starts < target && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_start_seen"}, {31'd0, n_starts >= target}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, s0;
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fifo_read_en", {31'd0, fifo_read_en}, 32'd0);
        check("rst_tx_start",     {31'd0, tx_start},     32'd0);
        check("rst_tx_data",      {24'd0, tx_data},      32'd0);
        check("rst_busy",         {31'd0, busy},         32'd0);
        check("rst_sent_count",   {16'd0, sent_count},   32'd0);
        check("rst_err_ack",      {31'd0, err_ack},      32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte, latency and pop width.
        frame_len = 10; ack_dly = 0;
        push(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        t0 = cyc;
        wait_quiet("single");
        check("single_rd_latency",    rd_rise_cyc, t0 + 1);
        check("single_start_latency", start_cyc,   t0 + 3);
        check("single_rd_width",      rd_last_run, 32'd1);
        check("single_starts",        n_starts,    32'd1);
        check("single_count",         {16'd0, sent_count}, 32'd1);
        check("single_busy",          {31'd0, busy}, 32'd0);

        // Burst of four with a randomised UART.
        rand_uart = 1'b1;
        s0 = n_starts;
        for (int b = 1; b <= 4; b++) push(DW'(b), 1'b1);
        wait_quiet("burst");
        check("burst_starts",  n_starts - s0, 32'd4);
        check("burst_count",   {16'd0, sent_count}, 32'd5);
        check("burst_exp_q",   exp_q.size(), 32'd0);
        check("burst_fifo",    fq.size(), 32'd0);

        // Ack timeout: UART never acknowledges.
        rand_uart = 1'b0; uart_ack_en = 1'b0;
        s0 = n_starts;
        push(8'h3C, 1'b1);
        wait_starts(s0 + 1, "timeout");
        for (int i = 0; i < 50 && cyc < start_cyc + 3; i++) @(negedge clk);
        check("timeout_err_early", {31'd0, err_ack}, 32'd0);
        @(negedge clk);
        check("timeout_err_set",   {31'd0, err_ack}, 32'd1);
        wait_quiet("timeout");
        check("timeout_count", {16'd0, sent_count}, 32'd5);
        uart_ack_en = 1'b1;
        push(8'h5A, 1'b1);
        wait_quiet("after_timeout");
        check("after_timeout_count", {16'd0, sent_count}, 32'd6);
        check("err_sticky",          {31'd0, err_ack},    32'd1);

        // Flush from IDLE with five bytes queued.
        enable = 1'b0;
        for (int b = 0; b < 5; b++) push(DW'(8'h80 + b), 1'b0);
        repeat (2) @(negedge clk);
        s0 = n_starts;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_quiet("flush");
        check("flush_fifo_empty", fq.size(), 32'd0);
        check("flush_no_start",   n_starts - s0, 32'd0);
        check("flush_busy",       {31'd0, busy}, 32'd0);
        check("flush_count",      {16'd0, sent_count}, 32'd6);
        check("flush_rd_run",     {31'd0, rd_last_run inside {5, 6}}, 32'd1);

        // Flush and enable drop while a frame is in flight.
        frame_len = 10; ack_dly = 0;
        enable = 1'b1;
        s0 = n_starts;
        push(8'hC1, 1'b1);
        for (int b = 0; b < 3; b++) push(DW'(8'hD0 + b), 1'b0);
        for (int i = 0; i < 100 && tx_busy !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        flush = 1'b1; enable = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        wait_quiet("midflush");
        check("midflush_starts", n_starts - s0, 32'd1);
        check("midflush_count",  {16'd0, sent_count}, 32'd7);
        check("midflush_fifo",   fq.size(), 32'd0);
        check("midflush_busy",   {31'd0, busy}, 32'd0);

        // Spacing between frame end and the next pop.
        frame_len = 5; ack_dly = 0;
        s0 = n_starts;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        wait_starts(s0 + 2, "gap");
        check("gap_spacing", rd_rise_cyc - busy_fall_cyc, 2 + EXP_GAP);
        wait_quiet("gap");
        check("gap_count", {16'd0, sent_count}, 32'd9);

        // Random traffic with pushes concurrent with pops.
        rand_uart = 1'b1;
        s0 = n_starts;
        for (int k = 0; k < 24; k++) begin
            push(DW'($urandom_range(0, 255)), 1'b1);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_quiet("random");
        check("random_starts", n_starts - s0, 32'd24);
        check("random_count",  {16'd0, sent_count}, ref_sent % (1 << CW));
        check("random_exp_q",  exp_q.size(), 32'd0);
        check("random_err",    {31'd0, err_ack}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
